// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG scheduler.
//   - Default LCG multiplier, increment and reset seed.
//   - Output permutation constants: xorshift amount and rotate-amount field.
//   - Sequencer state enum.
//   - lcg_step(): one LCG step, modulo 2^32.
package prng_pkg;

    localparam logic [31:0] MULT_DEFAULT = 32'h0019660D;
    localparam logic [31:0] INC_DEFAULT  = 32'h3C6EF35F;
    localparam logic [31:0] SEED_INIT    = 32'h00000001;

    // perm(s): x = s ^ (s >> PERM_SHIFT), then rotate x right by s[ROT_HI:ROT_LO]
    localparam int PERM_SHIFT = 6;
    localparam int ROT_HI     = 31;
    localparam int ROT_LO     = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2,
        WARM = 2'd3
    } state_e;

    // The 32-bit result context keeps only the low word of the product.
    function automatic logic [31:0] lcg_step(input logic [31:0] s,
                                             input logic [31:0] mult,
                                             input logic [31:0] inc);
        return s * mult + inc;
    endfunction

endpackage

// File: rtl/prng_permute.sv
// Combinational output permutation for the LCG state.
// Ports:
//   s  in  32  LCG state
//   p  out 32  permuted word: (s ^ (s >> 6)) rotated right by s[31:27]
module prng_permute
    import prng_pkg::*;
(
    input  logic [31:0] s,
    output logic [31:0] p
);

    logic [31:0] x;
    logic [4:0]  r;

    assign x = s ^ (s >> PERM_SHIFT);
    assign r = s[ROT_HI:ROT_LO];

    // Rotating via a doubled copy avoids ever shifting a 32-bit value by 32
    // when r == 0; the low word of {x,x} >> r is exactly rotr(x, r).
    assign p = 32'({x, x} >> r);

endmodule

// File: rtl/prng_sched.sv
// PRNG scheduler: owns the LCG state, runs warm-up after reset and reseed,
// and hands out one permuted word per grant to NUM_REQ round-robin requesters.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   seed_valid  in   reseed request
//   seed_data   in   new LCG state
//   seed_ready  out  high in IDLE only; seed taken when seed_valid && seed_ready
//   req         in   per-requester level request, held until its grant
//   gnt         out  one-hot grant pulse, one cycle
//   rnd_valid   out  rnd_data / rnd_id valid, coincident with gnt
//   rnd_data    out  permuted word (holds last value)
//   rnd_id      out  granted requester index (holds last value)
//   busy        out  high whenever not in IDLE
module prng_sched
    import prng_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] MULT         = MULT_DEFAULT,
    parameter logic [31:0] INC          = INC_DEFAULT,
    parameter logic [31:0] SEED_DEFAULT = SEED_INIT,
    parameter int          WARMUP       = 4,
    localparam int         ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid,
    input  logic [31:0]        seed_data,
    output logic               seed_ready,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [31:0]        rnd_data,
    output logic [ID_W-1:0]    rnd_id,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [31:0]        lcg_q, lcg_d;
    logic [7:0]         warm_cnt_q, warm_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    win_id_q, win_id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic [31:0]        rnd_data_q, rnd_data_d;
    logic [ID_W-1:0]    rnd_id_q, rnd_id_d;

    logic [31:0]        perm_out;
    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic [ID_W:0]      pick_idx;

    prng_permute u_permute (
        .s (lcg_q),
        .p (perm_out)
    );

    // Round-robin picker: first set request at or above rr_ptr, wrapping.
    always_comb begin
        pick_id    = rr_ptr_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (pick_idx >= (ID_W + 1)'(NUM_REQ)) begin
                pick_idx = pick_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!pick_found && req[pick_idx[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = pick_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lcg_d       = lcg_q;
        warm_cnt_d  = warm_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        win_id_d    = win_id_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        rnd_id_d    = rnd_id_q;

        case (state_q)
            IDLE: begin
                // A reseed takes priority over any pending request.
                if (seed_valid) begin
                    lcg_d      = seed_data;
                    warm_cnt_d = 8'(WARMUP);
                    state_d    = (WARMUP == 0) ? IDLE : WARM;
                end else if (pick_found) begin
                    win_id_d = pick_id;
                    state_d  = GEN;
                end
            end
            GEN: begin
                // Output registers are loaded here so the grant pulse and the
                // word appear together, straight from flops, during DONE.
                gnt_d[win_id_q] = 1'b1;
                rnd_valid_d     = 1'b1;
                rnd_data_d      = perm_out;
                rnd_id_d        = win_id_q;
                lcg_d           = lcg_step(lcg_q, MULT, INC);
                state_d         = DONE;
            end
            DONE: begin
                if (win_id_q == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_id_q + ID_W'(1);
                end
                state_d = IDLE;
            end
            WARM: begin
                lcg_d      = lcg_step(lcg_q, MULT, INC);
                warm_cnt_d = warm_cnt_q - 8'd1;
                if (warm_cnt_q == 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (WARMUP == 0) begin
                state_q <= IDLE;
            end else begin
                state_q <= WARM;
            end
            lcg_q       <= SEED_DEFAULT;
            warm_cnt_q  <= 8'(WARMUP);
            rr_ptr_q    <= '0;
            win_id_q    <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            rnd_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            lcg_q       <= lcg_d;
            warm_cnt_q  <= warm_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            win_id_q    <= win_id_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd_data   = rnd_data_q;
    assign rnd_id     = rnd_id_q;
    assign seed_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

    // A requester that drops its request after winning arbitration still gets
    // the word, but that is a protocol violation worth flagging.
    a_req_held_after_win: assert property (
        @(posedge clk) disable iff (!rst) (state_q == GEN) |-> req[win_id_q]
    );

endmodule

// File: doc/prng_sched.md
Name: prng_sched

Overview:
- Owns the 32-bit LCG state and the xorshift-rotate output permutation, and shares the generator between NUM_REQ requesters using round-robin arbitration.
- Accepts reseed commands and performs a warm-up of discarded steps after reset and after every reseed.
- Delivers one permuted 32-bit word per grant, tagged with the requester ID.
- Sits between the PRNG core and its consumers. This block is the sole sequencer of the LCG-plus-permutation datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MULT, 32'h0019660D, LCG multiplier
- INC, 32'h3C6EF35F, LCG increment
- SEED_DEFAULT, 32'h00000001, LCG state loaded at reset
- WARMUP, 4, LCG steps discarded after reset or reseed (0..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- seed_valid  in  1  reseed request
- seed_data  in  32  new LCG state
- seed_ready  out  1  seed accepted when seed_valid && seed_ready
- req  in  NUM_REQ  per-requester level request; held until its gnt
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rnd_valid  out  1  rnd_data/rnd_id valid; coincident with gnt
- rnd_data  out  32  permuted random word
- rnd_id  out  $clog2(NUM_REQ)  index of the granted requester
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async):
  - lcg_state=SEED_DEFAULT; gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0; rr_ptr=0.
  - FSM enters WARM with warm_cnt=WARMUP; if WARMUP=0 it enters IDLE.
- Permutation, perm(s):
  - x = s ^ (s>>6); r = s[31:27]; result = x rotated right by r.
  - r=0 returns x unchanged. Never shift by 32.
- LCG step: s_next = (s*MULT + INC) mod 2^32. Keep the low 32 bits only.
- FSM states:
  - IDLE:
    - seed_ready=1 (combinational, IDLE only).
    - If seed_valid: lcg_state<=seed_data, warm_cnt<=WARMUP, go WARM, or stay IDLE if WARMUP=0. Seed wins over pending req in the same cycle.
    - Else if |req: pick the first set req at or above rr_ptr, wrapping modulo NUM_REQ. Latch it as win_id, go GEN.
  - GEN: perm_reg<=perm(lcg_state) using the pre-step state; lcg_state<=step(lcg_state); go DONE.
  - DONE:
    - gnt[win_id]=1, rnd_valid=1, rnd_data=perm_reg, rnd_id=win_id, all for exactly this cycle.
    - rr_ptr<=(win_id+1) mod NUM_REQ; go IDLE.
  - WARM:
    - Each cycle lcg_state<=step(lcg_state) and warm_cnt decrements. Go IDLE after the cycle in which warm_cnt==1.
    - seed_ready=0 and req is ignored while in WARM.
- Latency and throughput:
  - req sampled in IDLE at cycle T gives gnt/rnd_valid at cycle T+2.
  - Maximum rate is one word per 3 cycles.
- Registers and defaults:
  - rnd_data and rnd_id are registered, and hold their last value when rnd_valid=0.
  - gnt is 0 outside DONE.
- Boundary rules:
  - req dropped after arbitration: the grant and word are still delivered, and the word is consumed (protocol violation; assertion flags it).
  - seed_valid during GEN, DONE or WARM: not accepted; seed_ready stays 0 until IDLE.
  - All req high: grants rotate strictly 0,1,2,3,0,...
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-GEN or mid-DONE: the in-flight word is discarded and no gnt is issued.

Decomposition:
- Package prng_pkg holds:
  - the default MULT, INC and SEED_DEFAULT constants;
  - the shift constant 6 and the rotate field position [31:27];
  - the FSM state enum (IDLE, GEN, DONE, WARM).
- Sub-module prng_permute: combinational 32-to-32 perm(s), reused by the existing core and by verification models.
- The round-robin picker stays inline in this block.

Test Plan:
- Reset release with WARMUP=0, SEED_DEFAULT=0, req=4'b0001: gnt[0] fires 2 cycles after sampling. rnd_data=0x00000000, rnd_id=0. A second request returns perm(0x3C6EF35F)=0x24793E91.
- All req=4'b1111 held for 12 cycles: 4 grants in order id 0,1,2,3, spaced 3 cycles apart, gnt always one-hot.
- seed_valid with seed_data=0x00000000 in the same IDLE cycle as req=4'b0010 (WARMUP=0): seed accepted first. The following grant to id1 returns 0x00000000.
- WARMUP=4, reseed 0x12345678: busy=1 for exactly 4 cycles and req is ignored. The first word equals perm of 0x12345678 stepped 4 times (reference model).
- seed_valid asserted during GEN: seed_ready=0 until IDLE, then accepted. The word already in flight uses the old state.
- rst asserted during DONE: gnt and rnd_valid drop immediately to 0, and lcg_state=SEED_DEFAULT after release.
